madd_result_accumulator: RTL

Downstream companion to the 8-lane 8-bit chained multiply-add stage. That stage has a fixed pipeline latency and no flow control. This block tracks which beats carry valid data and accumulates the per-beat 32-bit dot-product slices of one output element, seeded with a per-element bias. Completed sums go into an output FIFO with a valid/ready handshake, and a credit scheme keeps the uncontrolled multiply-add pipeline from ever overflowing that FIFO.

---
 rtl/madd_result_accumulator_if.sv | 31 +++
 rtl/madd_result_accumulator.sv | 138 +++++++++++++
 2 files changed

// File: rtl/madd_result_accumulator_if.sv
// -----------------------------------------------------------------------------
// madd_result_accumulator_if
// Bus that groups the signals around madd_result_accumulator.
//   ivalid/ilast/bias : upstream beat offer (operands go to the multiply-add
//                       stage in the same cycle)
//   oready            : upstream may launch a beat this cycle
//   madd_result       : multiply-add stage output, aligned MADD_LATENCY later
//   ovalid/result     : accumulated element, first-word-fall-through
//   iready            : downstream accepts result
// master = environment side, slave = accumulator side.
// -----------------------------------------------------------------------------
interface madd_result_accumulator_if;
  logic               ivalid;
  logic               ilast;
  logic signed [31:0] bias;
  logic               oready;
  logic signed [31:0] madd_result;
  logic               ovalid;
  logic               iready;
  logic signed [31:0] result;

  modport master (
    output ivalid, ilast, bias, madd_result, iready,
    input  oready, ovalid, result
  );

  modport slave (
    input  ivalid, ilast, bias, madd_result, iready,
    output oready, ovalid, result
  );
endinterface

// File: rtl/madd_result_accumulator.sv
// -----------------------------------------------------------------------------
// madd_result_accumulator
// Follows an uncontrolled fixed-latency multiply-add stage. A tag delay line
// marks which madd_result beats are real, a single accumulator adds the beats
// of one element on top of its bias, and finished sums land in a small
// first-word-fall-through FIFO. Upstream is throttled by counting FIFO entries
// plus element-ending beats still inside the multiply-add pipeline, so the
// FIFO can never overflow.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : madd_result_accumulator_if.slave (see interface header)
// -----------------------------------------------------------------------------
module madd_result_accumulator #(
  parameter int MADD_LATENCY = 4,
  parameter int OUT_DEPTH    = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  madd_result_accumulator_if.slave  bus
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  if (MADD_LATENCY < 1 || MADD_LATENCY > 16)
    $error("MADD_LATENCY must be in 1..16");
  if (OUT_DEPTH < 2 || OUT_DEPTH > 16 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0)
    $error("OUT_DEPTH must be a power of two in 2..16");

  typedef struct packed {
    logic               vld;
    logic               first;
    logic               last;
    logic signed [31:0] bias;
  } tag_t;

  // Two's complement add that wraps silently; no saturation on this path.
  function automatic logic signed [31:0] wrap_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    return a + b;
  endfunction

  tag_t               r_tag [MADD_LATENCY];
  logic               r_in_group;
  logic signed [31:0] r_acc;
  logic signed [31:0] r_mem [OUT_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_accept;
  tag_t               w_tag_in;
  tag_t               w_tag_out;
  logic signed [31:0] w_sum;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic [5:0]         w_inflight;
  logic [5:0]         w_credit_used;

  // Credit covers entries already in the FIFO plus element ends still in the
  // multiply-add pipeline; only registered state feeds oready.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MADD_LATENCY; i++)
      w_inflight = w_inflight + 6'(r_tag[i].vld & r_tag[i].last);
  end

  assign w_credit_used = 6'(r_count) + w_inflight;
  assign bus.oready    = resetn && (w_credit_used < 6'(OUT_DEPTH));
  assign w_accept      = bus.ivalid && bus.oready;

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.vld   = w_accept;
    w_tag_in.first = !r_in_group;
    w_tag_in.last  = bus.ilast;
    w_tag_in.bias  = bus.bias;
  end

  // ---- stage boundary: tag delay line, one stage per multiply-add cycle ----
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MADD_LATENCY; i++) r_tag[i] <= '0;
      r_in_group <= 1'b0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < MADD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
      if (w_accept) r_in_group <= !bus.ilast;
    end
  end

  assign w_tag_out = r_tag[MADD_LATENCY-1];
  assign w_sum     = wrap_add(w_tag_out.first ? w_tag_out.bias : r_acc,
                              bus.madd_result);
  assign w_push    = w_tag_out.vld && w_tag_out.last;
  assign w_pop     = bus.ovalid && bus.iready;
  assign w_full    = (r_count == CNT_W'(OUT_DEPTH));

  // ---- stage boundary: accumulator, consumes the tag aligned with madd_result ----
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
    end else if (w_tag_out.vld) begin
      r_acc <= w_tag_out.last ? '0 : w_sum;
    end
  end

  // ---- stage boundary: output FIFO ----
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_sum;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.ovalid = (r_count != '0);
  // Gated so the output reads zero whenever the FIFO is empty or in reset.
  assign bus.result = bus.ovalid ? r_mem[r_rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
                                  !(w_push && w_full && !w_pop));

endmodule
